// File: rtl/idex_stage_if.sv
// ID -> EX bundle for idex_stage: decoded ID fields and squash/freeze controls
// (master side), plus the registered EX-side view and the load-use stall (slave side).
interface idex_stage_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
);
  logic               id_valid;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic               id_uses_rt;
  logic [DATA_W-1:0]  id_rs_data;
  logic [DATA_W-1:0]  id_rt_data;
  logic [DATA_W-1:0]  id_imm;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               id_mem_write;
  logic               id_mem_to_reg;
  logic               id_alu_src;
  logic               id_reg_dst;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               flush;
  logic               ext_stall;

  logic               stall_o;
  logic               idex_valid;
  logic [REG_AW-1:0]  idex_rs;
  logic [REG_AW-1:0]  idex_rt;
  logic [REG_AW-1:0]  idex_dest;
  logic [DATA_W-1:0]  idex_rs_data;
  logic [DATA_W-1:0]  idex_rt_data;
  logic [DATA_W-1:0]  idex_imm;
  logic               idex_reg_write;
  logic               idex_mem_read;
  logic               idex_mem_write;
  logic               idex_mem_to_reg;
  logic               idex_alu_src;
  logic [ALUOP_W-1:0] idex_alu_op;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rs_data, id_rt_data, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
           id_alu_op, flush, ext_stall,
    input  stall_o, idex_valid, idex_rs, idex_rt, idex_dest, idex_rs_data, idex_rt_data,
           idex_imm, idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg,
           idex_alu_src, idex_alu_op
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rs_data, id_rt_data, id_imm,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
           id_alu_op, flush, ext_stall,
    output stall_o, idex_valid, idex_rs, idex_rt, idex_dest, idex_rs_data, idex_rt_data,
           idex_imm, idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg,
           idex_alu_src, idex_alu_op
  );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection,
// flush and external freeze. Define IDEX_PERF_CNT_EN for bubble/stall counters.
module idex_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  idex_stage_if.slave  bus
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]  bubble_cnt,
  output logic [31:0]  stall_cnt
`endif
);
  logic               r_valid;
  logic [REG_AW-1:0]  r_rs;
  logic [REG_AW-1:0]  r_rt;
  logic [REG_AW-1:0]  r_dest;
  logic [DATA_W-1:0]  r_rs_data;
  logic [DATA_W-1:0]  r_rt_data;
  logic [DATA_W-1:0]  r_imm;
  logic               r_reg_write;
  logic               r_mem_read;
  logic               r_mem_write;
  logic               r_mem_to_reg;
  logic               r_alu_src;
  logic [ALUOP_W-1:0] r_alu_op;

  logic w_rt_hit;
  logic w_stall;
  logic w_bubble;

  // Hazard check runs on the held EX state, so it stays meaningful during ext_stall.
  assign w_rt_hit = (r_rt == bus.id_rs) | (bus.id_uses_rt & (r_rt == bus.id_rt));
  assign w_stall  = r_valid & r_mem_read & (r_rt != '0) & bus.id_valid & w_rt_hit & ~bus.flush;
  assign w_bubble = bus.flush | w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dest       <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_op     <= '0;
    end else if (!bus.ext_stall) begin
      if (w_bubble) begin
        // Zeroed specifiers keep the forwarding unit from matching a bubble.
        r_valid      <= 1'b0;
        r_rs         <= '0;
        r_rt         <= '0;
        r_dest       <= '0;
        r_reg_write  <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
      end else begin
        r_valid      <= bus.id_valid;
        r_rs         <= bus.id_valid ? bus.id_rs : '0;
        r_rt         <= bus.id_valid ? bus.id_rt : '0;
        r_dest       <= !bus.id_valid ? '0 : (bus.id_reg_dst ? bus.id_rd : bus.id_rt);
        r_rs_data    <= bus.id_rs_data;
        r_rt_data    <= bus.id_rt_data;
        r_imm        <= bus.id_imm;
        r_reg_write  <= bus.id_valid & bus.id_reg_write;
        r_mem_read   <= bus.id_valid & bus.id_mem_read;
        r_mem_write  <= bus.id_valid & bus.id_mem_write;
        r_mem_to_reg <= bus.id_valid & bus.id_mem_to_reg;
        r_alu_src    <= bus.id_alu_src;
        r_alu_op     <= bus.id_alu_op;
      end
    end
  end

  assign bus.stall_o         = w_stall;
  assign bus.idex_valid      = r_valid;
  assign bus.idex_rs         = r_rs;
  assign bus.idex_rt         = r_rt;
  assign bus.idex_dest       = r_dest;
  assign bus.idex_rs_data    = r_rs_data;
  assign bus.idex_rt_data    = r_rt_data;
  assign bus.idex_imm        = r_imm;
  assign bus.idex_reg_write  = r_reg_write;
  assign bus.idex_mem_read   = r_mem_read;
  assign bus.idex_mem_write  = r_mem_write;
  assign bus.idex_mem_to_reg = r_mem_to_reg;
  assign bus.idex_alu_src    = r_alu_src;
  assign bus.idex_alu_op     = r_alu_op;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating event counters; frozen edges under ext_stall are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else if (!bus.ext_stall) begin
      if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif
endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage pipeline.
- Captures decoded operands, register specifiers and control bits at the end of ID.
- Presents them to EX and to the forwarding unit (idex_rs / idex_rt feed forwarding comparisons).
- On a load-use dependency it stalls PC and IF/ID and injects one bubble; it also handles branch flush and external (memory) stall.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register specifier width
- ALUOP_W, 4, ALU operation code width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source register 1
- id_rt  in  REG_AW  source register 2 / I-type destination
- id_rd  in  REG_AW  R-type destination
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_rs_data  in  DATA_W  register file read 1
- id_rt_data  in  DATA_W  register file read 2
- id_imm  in  DATA_W  sign-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  in  1 each  decoded control
- id_alu_op  in  ALUOP_W  ALU operation
- flush  in  1  branch/jump taken; squash ID instruction
- ext_stall  in  1  downstream (memory) stall; freeze this stage
- stall_o  out  1  load-use stall to PC and IF/ID write enables (active high)
- idex_valid  out  1  EX holds a real instruction
- idex_rs, idex_rt, idex_dest  out  REG_AW  specifiers to EX/forwarding; dest = reg_dst ? rd : rt
- idex_rs_data, idex_rt_data, idex_imm  out  DATA_W  registered operands
- idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg, idex_alu_src  out  1 each  registered control
- idex_alu_op  out  ALUOP_W  registered ALU op

Behaviour:
- Reset (async, rst_n low): every idex_* output is 0, including idex_valid. stall_o reads 0 while in reset because idex_mem_read=0.
- Hazard detection (combinational on current registered state):
  - stall_o = idex_valid & idex_mem_read & (idex_rt != 0) & id_valid & ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt))).
  - stall_o is forced 0 when flush=1, since the dependent instruction is being squashed anyway.
- Per-edge update, in priority order:
  1. ext_stall=1: hold all registers unchanged. stall_o is still computed from the held state; the upstream stall is the OR of both.
  2. flush=1: load a bubble.
  3. stall_o=1: load a bubble.
  4. Otherwise: load all id_* fields; idex_valid <= id_valid.
- Bubble definition:
  - idex_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg all 0.
  - idex_rs, idex_rt, idex_dest forced 0, so the forwarding unit never matches a bubble.
  - Data fields hold their previous values (don't care).
- id_valid=0 with no stall/flush: fields are loaded, but all write/mem controls and specifiers are gated to 0 exactly as a bubble.
- Load-use stall length is exactly one cycle. After the bubble, the load sits in EX/MEM and forwarding resolves the dependency. stall_o deasserts on the next cycle.
- Back-to-back load-use (load followed by a dependent load followed by a dependent use): each pair gives one bubble, independently.
- Register 0 never causes a stall.
- Reset asserted mid-stall: stall_o drops immediately (async) and the pipeline restarts empty.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- When defined, the block adds outputs bubble_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - bubble_cnt increments on every edge where a bubble is loaded (flush or load-use, not during ext_stall).
  - stall_cnt increments on every edge where stall_o=1 and ext_stall=0.
  - Both counters saturate at 32'hFFFF_FFFF.
- When undefined, these ports and all counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 with id_* = nonzero -> all idex_* = 0, stall_o=0. Release, load lw r8 (mem_read=1, rt=8) -> idex_rt=8, idex_mem_read=1, idex_valid=1 one edge later.
- Load-use: EX holds lw rt=8; ID add rs=8, rt=9, uses_rt=1 -> stall_o=1 that cycle; next edge idex_valid=0, idex_dest=0. ID add is held; the following edge loads add with idex_rs=8, stall_o=0.
- No false stall: EX lw rt=8; ID addi rs=3, rt=8, uses_rt=0 -> stall_o=0, addi loads normally. EX lw rt=0, ID rs=0 -> stall_o=0.
- Flush priority: load-use condition true and flush=1 -> stall_o=0, bubble loaded, idex_reg_write=0.
- ext_stall: hold for 3 cycles with id_* changing -> all idex_* unchanged. Release -> next id_* loaded on the first edge.
- With IDEX_PERF_CNT_EN: two load-use stalls plus one flush -> bubble_cnt=3, stall_cnt=2.
